counter_sat_wrap: RTL and testbench
===================================

Name: counter_sat_wrap

Overview:
- Parametrised up/down counter that generalises the fixed 4-bit incr/decr counter.
- Each cycle it adds an optional increment and subtracts an optional decrement, both signed-free unsigned steps, applied to the current value or to a reinitialisation value.
- Configurable width, step width and modulus (MAX_VALUE). Overflow handling is selectable as saturate or wrap.
- Adds sticky overflow/underflow flags and a threshold compare. Used for credit, occupancy and pointer tracking.

Parameters:
- WIDTH, 8: counter width in bits.
- STEP_W, 2: width of incr/decr; must satisfy 2^STEP_W-1 <= MAX_VALUE.
- MAX_VALUE, 2^WIDTH-1: largest legal count. Wrap modulus is MAX_VALUE+1.
- SATURATE, 1: 1 = clamp to [0, MAX_VALUE]; 0 = wrap modulo MAX_VALUE+1.
- RESET_VALUE, 0: value after reset; must be <= MAX_VALUE.

Ports:
- clk, input, 1: clock; all state is updated on the rising edge.
- rst_n, input, 1: asynchronous active-low reset.
- reinit, input, 1: replace the base value with initial_value this cycle and clear the sticky flags.
- initial_value, input, WIDTH: reinit load value; values above MAX_VALUE are clamped to MAX_VALUE.
- incr_valid, input, 1: qualifies incr.
- incr, input, STEP_W: increment amount.
- decr_valid, input, 1: qualifies decr.
- decr, input, STEP_W: decrement amount.
- flag_clr, input, 1: clear the sticky flags.
- thresh, input, WIDTH: compare level.
- value, output, WIDTH: registered count.
- value_next, output, WIDTH: combinational next count.
- overflow, output, 1: sticky; set when a result exceeded MAX_VALUE.
- underflow, output, 1: sticky; set when a result went below 0.
- at_zero, output, 1: value == 0.
- at_max, output, 1: value == MAX_VALUE.
- ge_thresh, output, 1: value >= thresh.

Behaviour:
- Reset (rst_n low, asynchronous):
  - value = RESET_VALUE; overflow = 0; underflow = 0.
  - Derived flags follow value immediately.
  - Release is synchronous to clk (no update on the cycle of deassertion edge beyond normal sampling).
- Base value: base = reinit ? min(initial_value, MAX_VALUE) : value.
- Step terms:
  - inc = incr_valid ? incr : 0.
  - dec = decr_valid ? decr : 0.
  - Simultaneous incr and decr are both applied in the same cycle.
- Arithmetic: raw = base + inc - dec, computed in WIDTH+2-bit signed so that no intermediate truncation occurs.
- Overflow and underflow detection:
  - ovf_now = raw > MAX_VALUE.
  - unf_now = raw < 0.
  - The two are mutually exclusive.
- SATURATE=1:
  - value_next = ovf_now ? MAX_VALUE : unf_now ? 0 : raw.
- SATURATE=0:
  - value_next = ovf_now ? raw-(MAX_VALUE+1) : unf_now ? raw+(MAX_VALUE+1) : raw.
  - A single correction is sufficient given the STEP_W constraint.
- value_next is purely combinational from the current inputs and value. It is valid in every cycle, including idle cycles, where value_next == value.
- Register update:
  - value <= value_next when reinit | incr_valid | decr_valid; otherwise value is held.
  - Latency is 1 cycle from input to value.
- Sticky flags, evaluated with clear before set:
  - overflow <= ((reinit|flag_clr) ? 0 : overflow) | (ovf_now & (incr_valid|decr_valid)).
  - underflow follows the same rule with unf_now.
  - An event in the same cycle as a clear still sets the flag.
- Derived flags: at_zero, at_max and ge_thresh are combinational from the registered value and thresh. ge_thresh is an unsigned compare.
- Boundary cases:
  - reinit with incr/decr: the step is applied to initial_value, not to the old value.
  - MAX_VALUE = 2^WIDTH-1 with wrap: behaves as natural modulo 2^WIDTH.
  - Reset mid-stream: all pending inputs are discarded; the first update after release uses RESET_VALUE as base.

Test Plan:
- Params WIDTH=4, MAX_VALUE=11, SATURATE=1, RESET_VALUE=0.
  - Assert rst_n=0 mid-count at value=7 → value=0 and flags=0 immediately, without waiting for a clock edge.
  - From value=10, incr_valid=1, incr=3 → value_next=11, value=11 next cycle, overflow=1, at_max=1.
  - Hold overflow through 3 idle cycles → overflow stays 1 and value stays 11.
  - flag_clr=1 together with decr_valid=1, decr=2 → overflow=0, value=9.
- Same params with SATURATE=0:
  - From value=10, incr=3 → value=1, overflow=1.
  - From value=1, decr=3 → value=10, underflow=1.
- From value=5, reinit=1 with initial_value=9, incr_valid=1, incr=2, decr_valid=1, decr=1 → value=10; previous sticky flags cleared.
- initial_value=15 with reinit=1 and no steps → value=11 (clamped), overflow=0.
- From value=6 with thresh=6 → ge_thresh=1; decr=1 → ge_thresh=0 next cycle.
- Random constrained-step sequence checked against a behavioural model of value, value_next and the sticky flags for ≥10k cycles, in both SATURATE modes.

Source files
------------

// File: rtl/counter_sat_wrap_if.sv
// Control and status bundle for counter_sat_wrap.
// The master drives steps, reinit and threshold; the slave returns the count and flags.
interface counter_sat_wrap_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STEP_W = 2
);
  logic              reinit;
  logic [WIDTH-1:0]  initial_value;
  logic              incr_valid;
  logic [STEP_W-1:0] incr;
  logic              decr_valid;
  logic [STEP_W-1:0] decr;
  logic              flag_clr;
  logic [WIDTH-1:0]  thresh;
  logic [WIDTH-1:0]  value;
  logic [WIDTH-1:0]  value_next;
  logic              overflow;
  logic              underflow;
  logic              at_zero;
  logic              at_max;
  logic              ge_thresh;

  modport master (
    output reinit, initial_value, incr_valid, incr, decr_valid, decr, flag_clr, thresh,
    input  value, value_next, overflow, underflow, at_zero, at_max, ge_thresh
  );

  modport slave (
    input  reinit, initial_value, incr_valid, incr, decr_valid, decr, flag_clr, thresh,
    output value, value_next, overflow, underflow, at_zero, at_max, ge_thresh
  );
endinterface

// File: rtl/counter_sat_wrap.sv
// Parametrised up/down counter with saturate or wrap at MAX_VALUE,
// sticky overflow/underflow flags and a threshold compare.
module counter_sat_wrap #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned STEP_W      = 2,
  parameter int unsigned MAX_VALUE   = (2 ** WIDTH) - 1,
  parameter bit          SATURATE    = 1'b1,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  counter_sat_wrap_if.slave   bus
);

  // Two guard bits keep base + inc - dec exact and signed.
  localparam int unsigned RW = WIDTH + 2;
  localparam logic signed [RW-1:0] MAX_S   = RW'(MAX_VALUE);
  localparam logic signed [RW-1:0] MOD_S   = RW'(MAX_VALUE + 1);
  localparam logic [WIDTH-1:0]     MAX_W   = WIDTH'(MAX_VALUE);
  localparam logic [WIDTH-1:0]     RESET_W = WIDTH'(RESET_VALUE);

  logic [WIDTH-1:0]     value_q, value_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic [WIDTH-1:0]     base_c;
  logic [STEP_W-1:0]    inc_c, dec_c;
  logic signed [RW-1:0] raw_c;
  logic                 ovf_now_c, unf_now_c, step_c;
  logic [WIDTH-1:0]     value_next_c;

  always_comb begin
    inc_c        = '0;
    dec_c        = '0;
    base_c       = value_q;
    raw_c        = '0;
    ovf_now_c    = 1'b0;
    unf_now_c    = 1'b0;
    step_c       = 1'b0;
    value_next_c = value_q;
    value_d      = value_q;
    ovf_d        = ovf_q;
    unf_d        = unf_q;

    if (bus.incr_valid) inc_c = bus.incr;
    if (bus.decr_valid) dec_c = bus.decr;
    if (bus.reinit) base_c = (bus.initial_value > MAX_W) ? MAX_W : bus.initial_value;

    raw_c     = $signed(RW'(base_c)) + $signed(RW'(inc_c)) - $signed(RW'(dec_c));
    ovf_now_c = (raw_c > MAX_S);
    unf_now_c = raw_c[RW-1];
    step_c    = bus.incr_valid | bus.decr_valid;

    // One correction suffices because a step never exceeds MAX_VALUE.
    if (SATURATE) begin
      if (ovf_now_c)      value_next_c = MAX_W;
      else if (unf_now_c) value_next_c = '0;
      else                value_next_c = WIDTH'(raw_c);
    end else begin
      if (ovf_now_c)      value_next_c = WIDTH'(raw_c - MOD_S);
      else if (unf_now_c) value_next_c = WIDTH'(raw_c + MOD_S);
      else                value_next_c = WIDTH'(raw_c);
    end

    if (bus.reinit | step_c) value_d = value_next_c;
    // Clear first so a same-cycle event still sets the flag.
    ovf_d = ((bus.reinit | bus.flag_clr) ? 1'b0 : ovf_q) | (ovf_now_c & step_c);
    unf_d = ((bus.reinit | bus.flag_clr) ? 1'b0 : unf_q) | (unf_now_c & step_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= RESET_W;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      value_q <= value_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.value      = value_q;
  assign bus.value_next = value_next_c;
  assign bus.overflow   = ovf_q;
  assign bus.underflow  = unf_q;
  assign bus.at_zero    = (value_q == '0);
  assign bus.at_max     = (value_q == MAX_W);
  assign bus.ge_thresh  = (value_q >= bus.thresh);

endmodule

// File: tb/tb_counter_sat_wrap.sv
// Bench for counter_sat_wrap: saturating and wrapping instances driven in lockstep,
// expectations queued by the driver and checked by an independent monitor.
module tb_counter_sat_wrap;

  localparam int W    = 4;
  localparam int SW   = 2;
  localparam int MAXV = 11;
  localparam int MODV = MAXV + 1;

  typedef struct {
    int vn;
    int v;
    int o;
    int u;
    int z;
    int m;
    int g;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  bit   done;

  exp_t q_s[$];
  exp_t q_w[$];

  // Reference state per instance: [0] saturate, [1] wrap
  int m_val[2];
  int m_ovf[2];
  int m_unf[2];

  counter_sat_wrap_if #(.WIDTH(W), .STEP_W(SW)) if_s ();
  counter_sat_wrap_if #(.WIDTH(W), .STEP_W(SW)) if_w ();

  counter_sat_wrap #(.WIDTH(W), .STEP_W(SW), .MAX_VALUE(MAXV), .SATURATE(1'b1), .RESET_VALUE(0))
    u_sat (.clk(clk), .rst_n(rst_n), .bus(if_s));
  counter_sat_wrap #(.WIDTH(W), .STEP_W(SW), .MAX_VALUE(MAXV), .SATURATE(1'b0), .RESET_VALUE(0))
    u_wrap (.clk(clk), .rst_n(rst_n), .bus(if_w));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int wrap_mod(input int x);
    return ((x % MODV) + MODV) % MODV;
  endfunction

  // Applies one cycle of stimulus to both instances and queues the expected outputs.
  task automatic step(input bit rst, input bit ri, input int iv_val, input bit iv, input int ia,
                      input bit dv, input int da, input bit fc, input int th);
    @(posedge clk);
    #1;
    rst_n                = rst;
    if_s.reinit          = ri;           if_w.reinit        = ri;
    if_s.initial_value   = W'(iv_val);   if_w.initial_value = W'(iv_val);
    if_s.incr_valid      = iv;           if_w.incr_valid    = iv;
    if_s.incr            = SW'(ia);      if_w.incr          = SW'(ia);
    if_s.decr_valid      = dv;           if_w.decr_valid    = dv;
    if_s.decr            = SW'(da);      if_w.decr          = SW'(da);
    if_s.flag_clr        = fc;           if_w.flag_clr      = fc;
    if_s.thresh          = W'(th);       if_w.thresh        = W'(th);
    for (int k = 0; k < 2; k++) begin
      int   base, raw, vn;
      bit   ev_o, ev_u;
      exp_t e;
      if (!rst) begin
        m_val[k] = 0;
        m_ovf[k] = 0;
        m_unf[k] = 0;
      end
      base = ri ? ((iv_val > MAXV) ? MAXV : iv_val) : m_val[k];
      raw  = base + (iv ? ia : 0) - (dv ? da : 0);
      ev_o = (raw > MAXV);
      ev_u = (raw < 0);
      if (k == 0) vn = ev_o ? MAXV : (ev_u ? 0 : raw);
      else        vn = wrap_mod(raw);
      e.vn = vn;
      e.v  = m_val[k];
      e.o  = m_ovf[k];
      e.u  = m_unf[k];
      e.z  = (m_val[k] == 0) ? 1 : 0;
      e.m  = (m_val[k] == MAXV) ? 1 : 0;
      e.g  = (m_val[k] >= th) ? 1 : 0;
      if (k == 0) q_s.push_back(e);
      else        q_w.push_back(e);
      if (rst) begin
        if (ri || iv || dv) m_val[k] = vn;
        m_ovf[k] = ((ri || fc) ? 0 : m_ovf[k]) | ((ev_o && (iv || dv)) ? 1 : 0);
        m_unf[k] = ((ri || fc) ? 0 : m_unf[k]) | ((ev_u && (iv || dv)) ? 1 : 0);
      end
    end
  endtask

  task automatic idle(input int th);
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, th);
  endtask

  task automatic load(input int v, input int th);
    step(1'b1, 1'b1, v, 1'b0, 0, 1'b0, 0, 1'b0, th);
  endtask

  // Monitor: compares whatever the DUTs present against the oldest queued expectation.
  always @(negedge clk) begin
    if (!done && q_s.size() > 0 && q_w.size() > 0) begin
      exp_t es, ew;
      es = q_s.pop_front();
      ew = q_w.pop_front();
      chk("sat.value_next", int'(if_s.value_next), es.vn);
      chk("sat.value",      int'(if_s.value),      es.v);
      chk("sat.overflow",   int'(if_s.overflow),   es.o);
      chk("sat.underflow",  int'(if_s.underflow),  es.u);
      chk("sat.at_zero",    int'(if_s.at_zero),    es.z);
      chk("sat.at_max",     int'(if_s.at_max),     es.m);
      chk("sat.ge_thresh",  int'(if_s.ge_thresh),  es.g);
      chk("wrap.value_next", int'(if_w.value_next), ew.vn);
      chk("wrap.value",      int'(if_w.value),      ew.v);
      chk("wrap.overflow",   int'(if_w.overflow),   ew.o);
      chk("wrap.underflow",  int'(if_w.underflow),  ew.u);
      chk("wrap.at_zero",    int'(if_w.at_zero),    ew.z);
      chk("wrap.at_max",     int'(if_w.at_max),     ew.m);
      chk("wrap.ge_thresh",  int'(if_w.ge_thresh),  ew.g);
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    done  = 1'b0;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      m_val[k] = 0;
      m_ovf[k] = 0;
      m_unf[k] = 0;
    end
    if_s.reinit = 1'b0; if_s.initial_value = '0; if_s.incr_valid = 1'b0; if_s.incr = '0;
    if_s.decr_valid = 1'b0; if_s.decr = '0; if_s.flag_clr = 1'b0; if_s.thresh = '0;
    if_w.reinit = 1'b0; if_w.initial_value = '0; if_w.incr_valid = 1'b0; if_w.incr = '0;
    if_w.decr_valid = 1'b0; if_w.decr = '0; if_w.flag_clr = 1'b0; if_w.thresh = '0;

    step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    step(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    idle(0);

    // Asynchronous reset while counting at 7
    load(7, 0);
    step(1'b1, 1'b0, 0, 1'b1, 1, 1'b0, 0, 1'b0, 0);
    step(1'b0, 1'b0, 0, 1'b1, 2, 1'b0, 0, 1'b0, 0);
    idle(0);

    // Overflow from 10 by 3, hold, then clear with a decrement
    load(10, 0);
    step(1'b1, 1'b0, 0, 1'b1, 3, 1'b0, 0, 1'b0, 0);
    idle(0); idle(0); idle(0);
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 2, 1'b1, 0);
    idle(0);

    // Underflow from 1 by 3
    load(1, 0);
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 3, 1'b0, 0);
    idle(0);

    // reinit with simultaneous steps applies to initial_value and clears flags
    load(5, 0);
    step(1'b1, 1'b1, 9, 1'b1, 2, 1'b1, 1, 1'b0, 0);
    idle(0);

    // Clamp of out-of-range initial_value
    step(1'b1, 1'b1, 15, 1'b0, 0, 1'b0, 0, 1'b0, 0);
    idle(0);

    // Threshold boundary
    load(6, 6);
    step(1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1, 1'b0, 6);
    idle(6);

    // Randomised sequence on both instances
    for (int n = 0; n < 12000; n++) begin
      bit rst, ri, iv, dv, fc;
      rst = ($urandom_range(0, 999) != 0);
      ri  = ($urandom_range(0, 19) == 0);
      iv  = ($urandom_range(0, 2) != 0);
      dv  = ($urandom_range(0, 2) != 0);
      fc  = ($urandom_range(0, 15) == 0);
      step(rst, ri, int'($urandom_range(0, 15)), iv, int'($urandom_range(0, 3)),
           dv, int'($urandom_range(0, 3)), fc, int'($urandom_range(0, 15)));
    end
    idle(0);

    @(negedge clk);
    #1;
    done = 1'b1;
    chk("scoreboard_drained", q_s.size() + q_w.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
